// File: rtl/cache_writeback_buffer.sv
// rtl/cache_writeback_buffer.sv - single-entry eviction write buffer between L1 cache and physical memory
module cache_writeback_buffer #(
    parameter int OFFSET_BITS = 4,
    parameter int LINE_WIDTH  = 128
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cache_read,
    input  logic                  cache_write,
    input  logic [15:0]           cache_address,
    input  logic [LINE_WIDTH-1:0] cache_wdata,
    output logic [LINE_WIDTH-1:0] cache_rdata,
    output logic                  cache_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [15:0]           pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        IDLE,
        ACK,
        FETCH,
        DRAIN
    } state_t;

    localparam logic [15:0] LINE_MASK = ~((16'd1 << OFFSET_BITS) - 16'd1);

    state_t                  state, state_next;
    logic                    buf_valid;
    logic [15:0]             buf_addr;
    logic [LINE_WIDTH-1:0]   buf_data;
    logic [LINE_WIDTH-1:0]   rdata;
    logic [15:0]             line_addr;
    logic                    line_match;
    logic                    load_hit;
    logic                    load_fill;
    logic                    capture;
    logic                    clear_valid;

    assign line_addr  = cache_address & LINE_MASK;
    assign line_match = buf_valid && (buf_addr == line_addr);

    // Read beats write beats drain; a conflicting write waits for the drain to free the entry.
    always_comb begin
        state_next  = state;
        load_hit    = 1'b0;
        load_fill   = 1'b0;
        capture     = 1'b0;
        clear_valid = 1'b0;
        case (state)
            IDLE: begin
                if (cache_read) begin
                    if (line_match) begin
                        load_hit   = 1'b1;
                        state_next = ACK;
                    end else begin
                        state_next = FETCH;
                    end
                end else if (cache_write) begin
                    if (!buf_valid || line_match) begin
                        capture    = 1'b1;
                        state_next = ACK;
                    end else begin
                        state_next = DRAIN;
                    end
                end else if (buf_valid) begin
                    state_next = DRAIN;
                end
            end
            ACK: state_next = IDLE;
            FETCH: begin
                if (pmem_resp) begin
                    load_fill  = 1'b1;
                    state_next = ACK;
                end
            end
            DRAIN: begin
                if (pmem_resp) begin
                    clear_valid = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            buf_valid <= 1'b0;
            buf_addr  <= '0;
            buf_data  <= '0;
            rdata     <= '0;
        end else begin
            state <= state_next;
            if (load_hit) begin
                rdata <= buf_data;
            end else if (load_fill) begin
                rdata <= pmem_rdata;
            end
            if (capture) begin
                buf_valid <= 1'b1;
                buf_addr  <= line_addr;
                buf_data  <= cache_wdata;
            end else if (clear_valid) begin
                buf_valid <= 1'b0;
            end
        end
    end

    assign cache_rdata = rdata;
    assign cache_resp  = (state == ACK);
    assign pmem_read   = (state == FETCH);
    assign pmem_write  = (state == DRAIN);

    always_comb begin
        pmem_address = '0;
        pmem_wdata   = '0;
        if (state == FETCH) begin
            pmem_address = line_addr;
        end else if (state == DRAIN) begin
            pmem_address = buf_addr;
            pmem_wdata   = buf_data;
        end
    end

endmodule
